// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Holds the FSM state encodings, the opcodes the controller understands,
// the encodings driven onto the ALU control and mux select lines, and the
// packed control word passed from the output decoder to the top module.
package mips_ctrl_pkg;

  // The debug port exposes these numeric values directly, so the
  // encodings are fixed rather than left to the tools.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEXEC = 4'd10,
    ADDIWB   = 4'd11
  } ctrlStateT;

  // Opcodes, taken from instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // {AluOp1, AluOp0} as understood by the ALU control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-input mux selects
  localparam logic [1:0] SRCB_RT       = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  // PC source mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every datapath control produced in one cycle
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
  } ctrlWordT;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational decode from the controller state to the full datapath
// control word. Anything a state does not mention stays 0.
// Ports:
//   state    - current FSM state
//   memReady - effective memory handshake; only FETCH looks at it
//   ctrl     - decoded control word
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  ctrlStateT state,
  input  logic      memReady,
  output ctrlWordT  ctrl
);

  // Start each state from an all-zero control word and raise only what that
  // step needs. Illegal encodings fall through to the all-zero default.
  // FETCH is the only state that also depends on the handshake: IR and PC
  // must load only in the cycle where the fetched word is actually present.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.iorD     = 1'b0;
        ctrl.irWrite  = memReady;
        ctrl.aluSrcA  = 1'b0;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.pcWrite  = memReady;
        ctrl.pcSource = PCSRC_ALU;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is being decoded
        ctrl.aluSrcA = 1'b0;
        ctrl.aluSrcB = SRCB_IMM_SHL2;
        ctrl.aluOp   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
        ctrl.regDst   = 1'b0;
      end
      MEMWRITE: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      EXECUTE: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_RT;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b0;
        ctrl.regDst   = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_RT;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      ADDIEXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b0;
        ctrl.regDst   = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the 32-bit multicycle MIPS core. It sequences
// fetch / decode / execute / memory / writeback and drives every datapath
// enable, mux select and the AluOp pair into the ALU control unit.
// Ports:
//   clk, rst           - rising-edge clock, async active-high reset
//   opcode             - instr[31:26]; only looked at in DECODE and MEMADR
//   mem_ready          - memory finishes the current access this cycle
//   PCWrite .. PCSource - datapath controls (Moore decode of the state)
//   AluOp1, AluOp0     - 00 add, 01 subtract, 10 use funct field
//   illegal_op         - registered one-cycle pulse after an unknown opcode
//   state_dbg          - current state encoding
// Parameter MEM_WAIT_EN: 1 = memory steps wait for mem_ready, 0 = never wait.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       AluOp1,
  output logic       AluOp0,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  ctrlStateT state;
  ctrlStateT nextState;
  logic      memReady;
  logic      illegalNext;
  ctrlWordT  decoded;
  ctrlWordT  ctrl;

  // With waiting disabled the memory is treated as always finishing at once
  assign memReady = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Next-state selection. The memory steps (FETCH, MEMREAD, MEMWRITE) hold
  // until the handshake completes. DECODE dispatches on the opcode and
  // flags anything it does not recognise; MEMADR only needs to tell a store
  // from a load. Unused encodings recover to FETCH.
  always_comb begin
    nextState   = FETCH;
    illegalNext = 1'b0;
    case (state)
      FETCH:    nextState = memReady ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = EXECUTE;
          OP_BEQ:       nextState = BRANCH;
          OP_ADDI:      nextState = ADDIEXEC;
          OP_J:         nextState = JUMP;
          default: begin
            nextState   = FETCH;
            illegalNext = 1'b1;
          end
        endcase
      end
      MEMADR:   nextState = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  nextState = memReady ? MEMWB : MEMREAD;
      MEMWB:    nextState = FETCH;
      MEMWRITE: nextState = memReady ? FETCH : MEMWRITE;
      EXECUTE:  nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BRANCH:   nextState = FETCH;
      JUMP:     nextState = FETCH;
      ADDIEXEC: nextState = ADDIWB;
      ADDIWB:   nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  // State register plus the registered illegal-opcode pulse. The pulse is
  // raised for the single cycle after DECODE rejected the opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      state      <= nextState;
      illegal_op <= illegalNext;
    end
  end

  mips_ctrl_outdec uOutDec (
    .state    (state),
    .memReady (memReady),
    .ctrl     (decoded)
  );

  // The state register already sits in FETCH during reset, but FETCH drives
  // a memory read; forcing the word to zero keeps the datapath quiet until
  // reset is released.
  assign ctrl = rst ? '0 : decoded;

  assign PCWrite     = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign IRWrite     = ctrl.irWrite;
  assign MemtoReg    = ctrl.memtoReg;
  assign RegDst      = ctrl.regDst;
  assign RegWrite    = ctrl.regWrite;
  assign AluSrcA     = ctrl.aluSrcA;
  assign AluSrcB     = ctrl.aluSrcB;
  assign AluOp1      = ctrl.aluOp[1];
  assign AluOp0      = ctrl.aluOp[0];
  assign PCSource    = ctrl.pcSource;
  assign state_dbg   = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. A reference model keeps,
// for the instruction in flight, the list of steps it passes through and
// advances along that list, repeating memory steps while mem_ready is low.
// Directed sequences cover reset, each instruction class, stalls, an illegal
// opcode and an async reset mid-load; the rest is randomized.
module tb_mips_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, AluSrcA, AluOp1, AluOp0;
  logic [1:0] AluSrcB, PCSource;
  logic       illegal_op;
  logic [3:0] state_dbg;
  logic [15:0] dutCtrl;

  int errors;
  int checks;

  // Reference model state
  int         route[$];
  int         routeIdx;
  logic [5:0] instrOp;
  logic       expIllegal;

  mips_multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .AluSrcA     (AluSrcA),
    .AluSrcB     (AluSrcB),
    .AluOp1      (AluOp1),
    .AluOp0      (AluOp0),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .state_dbg   (state_dbg)
  );

  assign dutCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB,
                    AluOp1, AluOp0, PCSource};

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h",
               tag, $time, actual, expected);
    end
  endtask

  // Expected control word for a step, written straight from the state table.
  // Packing order matches dutCtrl.
  function automatic logic [15:0] expCtrl(input int st, input logic rdy);
    logic pcW = 0, pcWC = 0, iorD = 0, mRd = 0, mWr = 0, irW = 0;
    logic m2r = 0, rDst = 0, rW = 0, srcA = 0;
    logic [1:0] srcB = 2'b00, aluOp = 2'b00, pcSrc = 2'b00;
    case (st)
      0: begin mRd = 1; irW = rdy; pcW = rdy; srcB = 2'b01; end
      1: begin srcB = 2'b11; end
      2: begin srcA = 1; srcB = 2'b10; end
      3: begin mRd = 1; iorD = 1; end
      4: begin rW = 1; m2r = 1; end
      5: begin mWr = 1; iorD = 1; end
      6: begin srcA = 1; aluOp = 2'b10; end
      7: begin rW = 1; rDst = 1; end
      8: begin srcA = 1; aluOp = 2'b01; pcWC = 1; pcSrc = 2'b01; end
      9: begin pcW = 1; pcSrc = 2'b10; end
      10: begin srcA = 1; srcB = 2'b10; end
      11: begin rW = 1; end
      default: ;
    endcase
    return {pcW, pcWC, iorD, mRd, mWr, irW, m2r, rDst, rW, srcA, srcB, aluOp, pcSrc};
  endfunction

  function automatic logic isLegal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Start a new instruction: build the list of steps it will walk through
  task automatic loadInstr(input logic [5:0] op);
    instrOp = op;
    route.delete();
    route.push_back(0);
    route.push_back(1);
    case (op)
      6'b100011: begin route.push_back(2); route.push_back(3); route.push_back(4); end
      6'b101011: begin route.push_back(2); route.push_back(5); end
      6'b000000: begin route.push_back(6); route.push_back(7); end
      6'b000100: route.push_back(8);
      6'b001000: begin route.push_back(10); route.push_back(11); end
      6'b000010: route.push_back(9);
      default: ;
    endcase
    routeIdx = 0;
  endtask

  function automatic logic [5:0] pickOp();
    case ($urandom_range(0, 7))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'b111111;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic modelReset();
    expIllegal = 1'b0;
    loadInstr(pickOp());
  endtask

  // Advance the model across one rising edge
  task automatic modelStep(input logic rdy);
    int cur;
    cur = route[routeIdx];
    expIllegal = (cur == 1) && !isLegal(instrOp);
    if ((cur == 0 || cur == 3 || cur == 5) && !rdy) begin
      // memory step stalls
    end else if (routeIdx == route.size() - 1) begin
      loadInstr(pickOp());
    end else begin
      routeIdx++;
    end
  endtask

  // One clock cycle: drive inputs, check outputs, cross the edge, update model.
  // Called about 2 ns after a rising edge. Opcode is only meaningful in
  // DECODE and MEMADR; elsewhere it is scrambled to show it is ignored.
  task automatic applyStimulus(input logic forceRdy, input logic rdyVal);
    int   cur;
    logic rdy;
    cur = route[routeIdx];
    rdy = forceRdy ? rdyVal : ($urandom_range(0, 3) != 0);
    mem_ready = rdy;
    opcode = (cur == 1 || cur == 2) ? instrOp : 6'($urandom);
    #1;
    checkOutput("state", 32'(state_dbg), 32'(cur));
    checkOutput("ctrl", 32'(dutCtrl), 32'(expCtrl(cur, rdy)));
    checkOutput("illegalOp", 32'(illegal_op), 32'(expIllegal));
    checkOutput("rdWrExclusive", 32'(MemRead & MemWrite), 32'd0);
    @(posedge clk);
    modelStep(rdy);
    #2;
  endtask

  initial begin
    int guard;
    logic [5:0] dirOps[5];
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b0;
    dirOps    = '{6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};

    // Held in reset for three cycles: everything quiet, state FETCH
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rstCtrl", 32'(dutCtrl), 32'd0);
      checkOutput("rstState", 32'(state_dbg), 32'd0);
      checkOutput("rstIllegal", 32'(illegal_op), 32'd0);
    end
    #1;
    rst = 1'b0;
    modelReset();

    // R-type with memory always ready
    loadInstr(6'b000000);
    repeat (4) applyStimulus(1'b1, 1'b1);

    // lw with two fetch stalls and one read stall: eight cycles
    loadInstr(6'b100011);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);

    // sw, beq, j, addi and an illegal opcode, each with memory always ready
    foreach (dirOps[i]) begin
      int len;
      loadInstr(dirOps[i]);
      len = route.size();
      repeat (len) applyStimulus(1'b1, 1'b1);
    end

    // Random instruction mix with random memory stalls
    repeat (300) applyStimulus(1'b0, 1'b0);

    // Async reset in the middle of a load's MEMREAD step
    guard = 0;
    while (routeIdx != 0 && guard < 30) begin
      applyStimulus(1'b0, 1'b0);
      guard++;
    end
    if (guard >= 30) checkOutput("reachFetchTimeout", 32'd1, 32'd0);
    loadInstr(6'b100011);
    repeat (3) applyStimulus(1'b1, 1'b1);
    mem_ready = 1'b0;
    #1;
    checkOutput("preRstState", 32'(state_dbg), 32'd3);
    checkOutput("preRstMemRead", 32'(MemRead), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midRstCtrl", 32'(dutCtrl), 32'd0);
    checkOutput("midRstState", 32'(state_dbg), 32'd0);
    checkOutput("midRstIllegal", 32'(illegal_op), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("postRstState", 32'(state_dbg), 32'd0);
    modelReset();
    repeat (40) applyStimulus(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
